// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback stage: data select, 32x32 register file, bypassed read ports
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   wb_in_wb            {reserved, valid, mem_to_reg, reg_write}
//   wb_in_data_in       load data from MEM
//   wb_in_alu_result    ALU result from MEM
//   wb_in_rd_addr       destination register
//   rs1_addr/rs2_addr   decode read addresses
//   rs1_data/rs2_data   combinational read data with same-cycle write bypass
//   fwd_en/addr/data    in-flight writeback for EX forwarding
//   last_wr_addr/data   registered record of the most recent commit
//   retired             registered count of valid instructions
module wb_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              wb_in_wb,
    input  logic [XLEN-1:0]         wb_in_data_in,
    input  logic [XLEN-1:0]         wb_in_alu_result,
    input  logic [$clog2(NREG)-1:0] wb_in_rd_addr,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    fwd_en,
    output logic [$clog2(NREG)-1:0] fwd_addr,
    output logic [XLEN-1:0]         fwd_data,
    output logic [$clog2(NREG)-1:0] last_wr_addr,
    output logic [XLEN-1:0]         last_wr_data,
    output logic [31:0]             retired
);
    localparam int AW = $clog2(NREG);

    logic reg_write;
    logic mem_to_reg;
    logic valid;
    logic we;
    logic [XLEN-1:0] wdata;

    // Register 0 is hard-wired to zero, so storage starts at index 1.
    logic [XLEN-1:0] regs_q [NREG-1:1];
    logic [AW-1:0]   last_wr_addr_q;
    logic [XLEN-1:0] last_wr_data_q;
    logic [31:0]     retired_q;
    logic [31:0]     retired_d;

    assign reg_write  = wb_in_wb[0];
    assign mem_to_reg = wb_in_wb[1];
    assign valid      = wb_in_wb[2];

    assign wdata = mem_to_reg ? wb_in_data_in : wb_in_alu_result;
    // Gating with rst keeps the bypass and forward path quiet while reset
    // discards the write.
    assign we    = reg_write & (wb_in_rd_addr != '0) & rst;

    assign fwd_en   = we;
    assign fwd_addr = wb_in_rd_addr;
    assign fwd_data = wdata;

    assign retired_d = retired_q + 32'd1;

    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        val = '0;
        if (addr != '0) begin
            if (we && (addr == wb_in_rd_addr)) begin
                val = wdata;
            end else begin
                for (int i = 1; i < NREG; i++) begin
                    if (addr == AW'(i)) begin
                        val = regs_q[i];
                    end
                end
            end
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            last_wr_addr_q <= '0;
            last_wr_data_q <= '0;
            retired_q      <= '0;
        end else begin
            if (we) begin
                for (int i = 1; i < NREG; i++) begin
                    if (wb_in_rd_addr == AW'(i)) begin
                        regs_q[i] <= wdata;
                    end
                end
                last_wr_addr_q <= wb_in_rd_addr;
                last_wr_data_q <= wdata;
            end
            if (valid) begin
                retired_q <= retired_d;
            end
        end
    end

    assign last_wr_addr = last_wr_addr_q;
    assign last_wr_data = last_wr_data_q;
    assign retired      = retired_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized self-checking bench for wb_regfile
module tb_wb_regfile;
    logic        clk;
    logic        rst;
    logic [3:0]  wb_in_wb;
    logic [31:0] wb_in_data_in;
    logic [31:0] wb_in_alu_result;
    logic [4:0]  wb_in_rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        fwd_en;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
    logic [4:0]  last_wr_addr;
    logic [31:0] last_wr_data;
    logic [31:0] retired;

    wb_regfile dut (
        .clk              (clk),
        .rst              (rst),
        .wb_in_wb         (wb_in_wb),
        .wb_in_data_in    (wb_in_data_in),
        .wb_in_alu_result (wb_in_alu_result),
        .wb_in_rd_addr    (wb_in_rd_addr),
        .rs1_addr         (rs1_addr),
        .rs2_addr         (rs2_addr),
        .rs1_data         (rs1_data),
        .rs2_data         (rs2_data),
        .fwd_en           (fwd_en),
        .fwd_addr         (fwd_addr),
        .fwd_data         (fwd_data),
        .last_wr_addr     (last_wr_addr),
        .last_wr_data     (last_wr_data),
        .retired          (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] m_regs [32];
    logic [4:0]  m_last_addr;
    logic [31:0] m_last_data;
    logic [31:0] m_ret;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic commit,
                                           input logic [4:0] rd, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (commit && a == rd) return wd;
        return m_regs[a];
    endfunction

    // One clock cycle: drive, check combinational outputs, clock, update model,
    // check registered outputs.
    task automatic cycle(input logic r, input logic [3:0] wb, input logic [31:0] din,
                         input logic [31:0] alu, input logic [4:0] rd,
                         input logic [4:0] a1, input logic [4:0] a2);
        logic        commit;
        logic [31:0] wd;
        rst = r; wb_in_wb = wb; wb_in_data_in = din; wb_in_alu_result = alu;
        wb_in_rd_addr = rd; rs1_addr = a1; rs2_addr = a2;
        commit = r && wb[0] && rd != 5'd0;
        wd = wb[1] ? din : alu;
        #2;
        check("rs1_data", rs1_data, m_read(a1, commit, rd, wd));
        check("rs2_data", rs2_data, m_read(a2, commit, rd, wd));
        check("fwd_en", {31'h0, fwd_en}, {31'h0, commit});
        check("fwd_addr", {27'h0, fwd_addr}, {27'h0, rd});
        check("fwd_data", fwd_data, wd);
        @(posedge clk);
        if (!r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_last_addr = 5'd0; m_last_data = 32'h0; m_ret = 32'h0;
        end else begin
            if (commit) begin
                m_regs[rd] = wd; m_last_addr = rd; m_last_data = wd;
            end
            if (wb[2]) m_ret = m_ret + 32'd1;
        end
        #1;
        check("retired", retired, m_ret);
        check("last_wr_addr", {27'h0, last_wr_addr}, {27'h0, m_last_addr});
        check("last_wr_data", last_wr_data, m_last_data);
    endtask

    initial begin
        logic [4:0] rd;
        logic [4:0] a1;
        logic [4:0] a2;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
        m_last_addr = 5'hX; m_last_data = 32'hX; m_ret = 32'hX;
        rst = 1'b0; wb_in_wb = 4'h0; wb_in_data_in = 32'h0; wb_in_alu_result = 32'h0;
        wb_in_rd_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(posedge clk); #1;

        // Reset, with a write presented that must be discarded
        cycle(1'b0, 4'b0111, 32'h1111_1111, 32'h2222_2222, 5'd3, 5'd3, 5'd3);
        cycle(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++)
            cycle(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 5'(a), 5'(31 - a));

        // ALU write with bypass, then storage read
        cycle(1'b1, 4'b0101, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
        cycle(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);

        // Write to x0 is a no-op but still retires
        cycle(1'b1, 4'b0111, 32'h1234_5678, 32'h0, 5'd0, 5'd0, 5'd0);

        // Counter wrap from FFFFFFFE
        force dut.retired_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_q;
        m_ret = 32'hFFFF_FFFE;
        #1;
        check("retired_preload", retired, m_ret);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 4'b0100, 32'hCAFE_0000, 32'hBEEF_0000, 5'(k + 1), 5'd5, 5'(k + 1));

        // Write during reset is discarded
        cycle(1'b1, 4'b0001, 32'h0, 32'hAAAA_0000, 5'd7, 5'd7, 5'd7);
        cycle(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);
        cycle(1'b0, 4'b0101, 32'h0, 32'h5555_FFFF, 5'd7, 5'd7, 5'd5);
        cycle(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd7, 5'd5);

        // Both ports hit the bypass via mem_to_reg
        cycle(1'b1, 4'b0011, 32'h0F0F_0F0F, 32'h1, 5'd9, 5'd9, 5'd9);
        cycle(1'b1, 4'b0000, 32'h0, 32'h0, 5'd0, 5'd9, 5'd9);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 29) != 0), 4'($urandom), $urandom, $urandom, rd, a1, a2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register outputs. Each cycle it selects the writeback value from ALU result or memory data, commits it to a 32×32-bit integer register file, and serves two decode-stage read ports with same-cycle write bypass. It also exposes the in-flight writeback for EX forwarding, a registered last-write record, and a retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: register count; the address width is 5.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `wb_in_wb`  in  4  writeback control: bit0 `reg_write`, bit1 `mem_to_reg`, bit2 `valid` (real instruction, not a bubble), bit3 reserved and ignored.
- `wb_in_data_in`  in  32  load data from the MEM stage.
- `wb_in_alu_result`  in  32  ALU result from the MEM stage.
- `wb_in_rd_addr`  in  5  destination register.
- `rs1_addr`, `rs2_addr`  in  5 each  decode read addresses.
- `rs1_data`, `rs2_data`  out  32 each  combinational read data.
- `fwd_en`  out  1  combinational; a write to a nonzero register is committing this cycle.
- `fwd_addr`  out  5  combinational; equals `wb_in_rd_addr`.
- `fwd_data`  out  32  combinational; the selected writeback value.
- `last_wr_addr`  out  5  registered address of the most recent committed write.
- `last_wr_data`  out  32  registered data of the most recent committed write.
- `retired`  out  32  registered count of valid instructions.

## Operation
- Writeback data: `wdata = mem_to_reg ? wb_in_data_in : wb_in_alu_result`.
- A commit is `we = reg_write & (rd_addr != 0) & rst`.
  - When `we` is 1, `regs[rd_addr] <= wdata` on the rising edge.
  - `reg_write` with `rd = 0` is a no-op.
- `valid` is not required for a write. A write with `valid = 0` still commits. `valid` gates only the `retired` counter.
- Read ports:
  - Address 0 returns 0, always.
  - Otherwise, if `we` is 1 and the read address equals `rd_addr`, the port returns `wdata` (bypass).
  - Otherwise the port returns `regs[addr]`.
  - Both ports may hit the same register or the bypass simultaneously; both return the same value.
- Forwarding: `fwd_en = we`. `fwd_data = wdata` regardless of `fwd_en`.
- Last-write record: on each commit, `last_wr_addr <= rd_addr` and `last_wr_data <= wdata`. Otherwise the record holds.
- Counter: `retired <= retired + 1` when `valid` is 1. Arithmetic is modulo 2^32; `FFFFFFFF` wraps to `00000000`.
- Register 0 storage is never written. It is held at 0 and is not implemented as a flop.

## Timing
- Reset (`rst` = 0 at an edge):
  - All of `regs[1..31]` become 0.
  - `last_wr_addr`, `last_wr_data` and `retired` become 0.
  - Any write or count presented in that cycle is discarded; reset wins.
- Combinational outputs during reset:
  - `fwd_en` = 0.
  - `rs*_data` read the storage with no bypass.
  - `fwd_data` tracks its inputs.
- Write-to-read latency:
  - 0 cycles via the bypass in the commit cycle.
  - 1 cycle via storage afterward.
- Registered outputs update 1 cycle after the commit or count edge.
- Reset deasserted mid-stream: the first edge with `rst` = 1 commits normally. There is no warm-up cycle.
- Back-to-back writes to the same register: the later write is visible the cycle after it. The bypass always reflects the current-cycle input only.
- No stall or enable input exists. The upstream register presents bubbles as `wb = 0`.

## Test plan
- Reset, then read all 32 addresses on both ports → all return 0. `retired` = 0, `last_wr_addr` = 0, `last_wr_data` = 0.
- Present `wb = 4'b0101`, `alu_result = 32'hDEADBEEF`, `rd = 5`, `rs1_addr = 5` → in the same cycle `rs1_data = DEADBEEF` (bypass) and `fwd_en` = 1; the next cycle reads `DEADBEEF` from storage, `last_wr_addr = 5`, `retired = 1`.
- Present `wb = 4'b0111`, `data_in = 32'h12345678`, `alu_result = 32'h0`, `rd = 0` → `rs1_data(0)` stays 0, `fwd_en` = 0, `last_wr` is unchanged, `retired` increments.
- Preload `retired` to `FFFFFFFE` by counting valid instructions (or by a force), then present 3 valid bubbles (`wb = 4'b0100`) → `retired` goes `FFFFFFFF`, then `00000000`, then `00000001`; the register file is unchanged.
- Write x7 = `AAAA0000`. Next cycle, present a write x7 = `5555FFFF` with `rst` = 0 → after the edge x7 = 0, `fwd_en` was 0 during that cycle, and `retired` = 0.
- Both ports at address 9 while writing x9 = `0F0F0F0F` via `mem_to_reg` → both ports return `0F0F0F0F` in the same cycle, and `fwd_data = 0F0F0F0F`.
